reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 5, giving the number of measure channels sharing the regfile write port.
REQ-002 SHALL have parameter DATA_W, default 64, giving the result word width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port raw_wr_en_i, input, N_CH bits: per-channel one-cycle write strobe from measure.
REQ-006 SHALL have port raw_wr_data_i, input, N_CH x DATA_W bits: per-channel result word, valid with its strobe.
REQ-007 SHALL have port reg_wr_en_o, output, 1 bit: regfile write strobe, at most one per cycle.
REQ-008 SHALL have port reg_wr_data_o, output, DATA_W bits: regfile write data.
REQ-009 SHALL have port reg_wr_ch_o, output, clog2(N_CH) bits: source channel of the current write.
REQ-010 SHALL have port ovf_o, output, N_CH bits: sticky per-channel overflow flags.
REQ-011 SHALL have port ovf_clr_i, input, 1 bit: single-cycle pulse that clears all of ovf_o.

Function
REQ-012 SHALL give each channel one holding slot (pending flag + DATA_W data); a strobe on raw_wr_en_i[k] loads slot k at that clock edge.
REQ-013 SHALL grant, each cycle, at most one pending slot, chosen round-robin: search starts at last_grant+1 mod N_CH and wraps.
REQ-014 SHALL register the granted slot to the outputs: reg_wr_en_o=1, reg_wr_data_o=slot data, reg_wr_ch_o=k, one cycle after grant.
REQ-015 SHALL clear the granted slot's pending flag at the grant edge.
REQ-016 SHALL give an uncontested strobe a latency of exactly 2 cycles: strobe in cycle t, reg_wr_en_o high in cycle t+2.
REQ-017 SHALL drive reg_wr_en_o low in any cycle without a grant in the previous cycle.
REQ-018 SHALL hold reg_wr_data_o and reg_wr_ch_o at their last values while reg_wr_en_o is low.
REQ-019 SHALL, when slot k is pending and not granted and a new strobe on k arrives, overwrite the slot with the new data and set ovf_o[k]=1.
REQ-020 SHALL, when slot k is granted in the same cycle a new strobe on k arrives, emit the old data, reload the slot with the new data (pending=1), and leave ovf_o[k] unchanged.
REQ-021 SHALL, when ovf_clr_i and a new overflow event coincide, set that ovf_o bit (set wins over clear).
REQ-022 SHALL update last_grant only on a grant, and SHALL leave it unchanged in idle cycles.
REQ-023 SHALL never lose a write under simultaneous strobes on all N_CH channels; all N_CH are emitted within N_CH consecutive cycles.

Reset
REQ-024 SHALL, while rst_i=1 at a clock edge, clear all pending flags, ovf_o=0, reg_wr_en_o=0, reg_wr_data_o=0, reg_wr_ch_o=0, and last_grant=N_CH-1 (so channel 0 has first priority).
REQ-025 SHALL discard pending slots and their strobes when reset is asserted mid-operation; no write SHALL be emitted in the cycle after reset is released.
REQ-026 SHALL ignore raw_wr_en_i in any cycle in which rst_i=1.

Structure
REQ-027 SHALL take N_CH, DATA_W and the channel-index typedef from the shared package dfm_pkg.
REQ-028 SHALL place round-robin selection in one sub-module, rr_arbiter (pending vector + last_grant in, one-hot grant + index out, combinational).
REQ-029 SHALL add no extra cycle on the grant path through rr_arbiter.

Verification
REQ-030 SHALL cover: single strobe ch2 data 0x1234 at cycle t -> reg_wr_en_o=1, ch=2, data=0x1234 at t+2 only.
REQ-031 SHALL cover: strobes on all 5 channels in one cycle after reset -> writes in order ch0,1,2,3,4 in 5 consecutive cycles; ovf_o=0.
REQ-032 SHALL cover: a second all-channel burst after the last grant went to ch1 -> order 2,3,4,0,1.
REQ-033 SHALL cover: ch3 strobes 0xA then 0xB on consecutive cycles while ch0..2 are pending -> only 0xB is emitted for ch3, ovf_o[3]=1; ovf_clr_i pulse -> ovf_o=0.
REQ-034 SHALL cover: ch1 strobe 0xC exactly in its grant cycle carrying 0xB -> 0xB emitted, then 0xC emitted next, ovf_o[1]=0.
REQ-035 SHALL cover: rst_i asserted with 3 slots pending -> no reg_wr_en_o pulse after release; outputs at reset values.

Source files
------------

// File: rtl/dfm_pkg.sv
// dfm_pkg: shared measure/regfile sizing and channel-index type
package dfm_pkg;
    localparam int N_CH   = 5;
    localparam int DATA_W = 64;
    localparam int CH_W   = $clog2(N_CH);
    typedef logic [CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts one past the last grant
module rr_arbiter #(
    parameter int N_CH = dfm_pkg::N_CH
) (
    input  logic [N_CH-1:0]         i_pend,
    input  logic [$clog2(N_CH)-1:0] i_last,
    output logic [N_CH-1:0]         o_gnt,
    output logic [$clog2(N_CH)-1:0] o_idx,
    output logic                    o_vld
);
    localparam int CW = $clog2(N_CH);
    logic [CW-1:0] w_k;
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_k   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_k = CW'((int'(i_last) + i) % N_CH);
            if (!o_vld && i_pend[w_k]) begin
                o_vld      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end
endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: funnels per-channel result strobes into one regfile write port
module reg_wr_arbiter #(
    parameter int N_CH   = dfm_pkg::N_CH,
    parameter int DATA_W = dfm_pkg::DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          raw_wr_en_i,
    input  logic [N_CH*DATA_W-1:0]   raw_wr_data_i,
    output logic                     reg_wr_en_o,
    output logic [DATA_W-1:0]        reg_wr_data_o,
    output logic [$clog2(N_CH)-1:0]  reg_wr_ch_o,
    output logic [N_CH-1:0]          ovf_o,
    input  logic                     ovf_clr_i
);
    localparam int CW = $clog2(N_CH);
    logic [N_CH-1:0]   r_pend;
    logic [DATA_W-1:0] r_data [N_CH];
    logic [N_CH-1:0]   r_ovf;
    logic [CW-1:0]     r_last;
    logic              r_en;
    logic [DATA_W-1:0] r_wdata;
    logic [CW-1:0]     r_ch;
    logic [N_CH-1:0]   w_gnt;
    logic [CW-1:0]     w_idx;
    logic              w_vld;
    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .i_pend (r_pend),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_vld  (w_vld)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend  <= '0;
            r_ovf   <= '0;
            r_last  <= CW'(N_CH - 1);
            r_en    <= 1'b0;
            r_wdata <= '0;
            r_ch    <= '0;
        end else begin
            r_en <= w_vld;
            if (w_vld) begin
                r_wdata <= r_data[w_idx];
                r_ch    <= w_idx;
                r_last  <= w_idx;
            end
            // A strobe landing on the granted slot reloads it; only an ungranted pending slot overflows
            r_pend <= raw_wr_en_i | (r_pend & ~w_gnt);
            r_ovf  <= (ovf_clr_i ? '0 : r_ovf) | (raw_wr_en_i & r_pend & ~w_gnt);
            for (int k = 0; k < N_CH; k++)
                if (raw_wr_en_i[k])
                    r_data[k] <= raw_wr_data_i[k*DATA_W +: DATA_W];
        end
    end
    assign reg_wr_en_o   = r_en;
    assign reg_wr_data_o = r_wdata;
    assign reg_wr_ch_o   = r_ch;
    assign ovf_o         = r_ovf;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed vectors with hand-computed expectations for reg_wr_arbiter
module tb_reg_wr_arbiter;
    localparam int N = 5;
    localparam int W = 64;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   en = '0;
    logic [N*W-1:0] wd = '0;
    logic           ovf_clr = 1'b0;
    logic           o_en;
    logic [W-1:0]   o_data;
    logic [2:0]     o_ch;
    logic [N-1:0]   o_ovf;
    int n_chk = 0;
    int n_pass = 0;
    int ord[5] = '{2, 3, 4, 0, 1};
    always #5 clk = ~clk;
    reg_wr_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .raw_wr_en_i   (en),
        .raw_wr_data_i (wd),
        .reg_wr_en_o   (o_en),
        .reg_wr_data_o (o_data),
        .reg_wr_ch_o   (o_ch),
        .ovf_o         (o_ovf),
        .ovf_clr_i     (ovf_clr)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set(input int k, input logic [63:0] v);
        en[k] = 1'b1;
        wd[k*W +: W] = v;
    endtask
    task automatic expect_wr(input string tag, input int ch, input logic [63:0] d);
        chk({tag, " en"}, 64'(o_en), 64'd1);
        chk({tag, " ch"}, 64'(o_ch), 64'(ch));
        chk({tag, " data"}, o_data, d);
    endtask
    task automatic expect_idle(input string tag);
        chk({tag, " en"}, 64'(o_en), 64'd0);
    endtask
    task automatic do_reset;
        rst = 1'b1;
        en = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask
    initial begin
        tick;
        tick;
        chk("rst en", 64'(o_en), 64'd0);
        chk("rst data", o_data, 64'd0);
        chk("rst ch", 64'(o_ch), 64'd0);
        chk("rst ovf", 64'(o_ovf), 64'd0);
        rst = 1'b0;
        // single strobe: visible exactly two cycles later, then held
        set(2, 64'h1234);
        tick;
        en = '0;
        expect_idle("single t+1");
        tick;
        expect_wr("single t+2", 2, 64'h1234);
        tick;
        expect_idle("single t+3");
        chk("hold data", o_data, 64'h1234);
        chk("hold ch", 64'(o_ch), 64'd2);
        // all channels at once after reset
        do_reset;
        for (int k = 0; k < N; k++) set(k, 64'h100 + 64'(k));
        tick;
        en = '0;
        for (int k = 0; k < N; k++) begin
            tick;
            expect_wr("burst0", k, 64'h100 + 64'(k));
        end
        tick;
        expect_idle("burst0 end");
        chk("burst0 ovf", 64'(o_ovf), 64'd0);
        // move last grant to ch1, then burst rotates from ch2
        set(1, 64'h51);
        tick;
        en = '0;
        tick;
        expect_wr("to ch1", 1, 64'h51);
        for (int k = 0; k < N; k++) set(k, 64'h200 + 64'(k));
        tick;
        en = '0;
        for (int i = 0; i < N; i++) begin
            tick;
            expect_wr("burst1", ord[i], 64'h200 + 64'(ord[i]));
        end
        tick;
        expect_idle("burst1 end");
        // overwrite of a waiting slot flags overflow
        do_reset;
        set(0, 64'h1);
        set(1, 64'h2);
        set(2, 64'h3);
        set(3, 64'hA);
        tick;
        en = '0;
        set(3, 64'hB);
        tick;
        en = '0;
        expect_wr("ovf ch0", 0, 64'h1);
        chk("ovf set", 64'(o_ovf), 64'h08);
        tick;
        expect_wr("ovf ch1", 1, 64'h2);
        tick;
        expect_wr("ovf ch2", 2, 64'h3);
        tick;
        expect_wr("ovf ch3", 3, 64'hB);
        tick;
        expect_idle("ovf end");
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("ovf clr", 64'(o_ovf), 64'd0);
        // clear and new overflow together: set wins
        do_reset;
        set(0, 64'h1);
        set(3, 64'h5);
        tick;
        en = '0;
        set(3, 64'h6);
        ovf_clr = 1'b1;
        tick;
        en = '0;
        ovf_clr = 1'b0;
        chk("set wins", 64'(o_ovf), 64'h08);
        expect_wr("set wins ch0", 0, 64'h1);
        tick;
        expect_wr("set wins ch3", 3, 64'h6);
        // strobe in the grant cycle reloads without overflow
        do_reset;
        set(0, 64'hA0);
        set(1, 64'hB);
        tick;
        en = '0;
        tick;
        expect_wr("reload ch0", 0, 64'hA0);
        set(1, 64'hC);
        tick;
        en = '0;
        expect_wr("reload old", 1, 64'hB);
        tick;
        expect_wr("reload new", 1, 64'hC);
        chk("reload ovf", 64'(o_ovf), 64'd0);
        tick;
        expect_idle("reload end");
        // reset mid-operation discards pending slots and strobes during reset
        do_reset;
        for (int k = 0; k < 3; k++) set(k, 64'h300 + 64'(k));
        tick;
        rst = 1'b1;
        en = '1;
        tick;
        tick;
        en = '0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_idle("midrst");
            chk("midrst data", o_data, 64'd0);
            chk("midrst ch", 64'(o_ch), 64'd0);
        end
        chk("midrst ovf", 64'(o_ovf), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
